chnl_acum_ctrl: RTL and testbench

//  Sequencer for the channel-accumulation datapath. Accepts conv result columns from upstream (valid/ready),

---
 rtl/acum_pkg.sv | 13 +
 rtl/acum_idx_cnt.sv | 42 ++++
 rtl/chnl_acum_ctrl.sv | 117 +++++++++++
 tb/tb_chnl_acum_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/acum_pkg.sv
// rtl/acum_pkg.sv - shared defaults and state encoding for the channel-accumulation sequencer
package acum_pkg;

    localparam int WID_DEF  = 56;
    localparam int CHNL_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } acum_state_t;

endpackage

// File: rtl/acum_idx_cnt.sv
// rtl/acum_idx_cnt.sv - nested column/channel index counter with clear, enable and last flags
module acum_idx_cnt #(
    parameter int WID  = 56,
    parameter int CHNL = 64,
    parameter int CW   = $clog2(WID),
    parameter int NW   = $clog2(CHNL) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [NW-1:0] chnl_max,
    output logic [CW-1:0] col,
    output logic          col_last,
    output logic          chnl_last,
    output logic          first_chnl
);

    logic [NW-1:0] chnl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            chnl <= '0;
        end else if (clr) begin
            col  <= '0;
            chnl <= '0;
        end else if (en) begin
            if (col_last) begin
                col  <= '0;
                chnl <= chnl + NW'(1);
            end else begin
                col  <= col + CW'(1);
            end
        end
    end

    assign col_last   = (col == CW'(WID - 1));
    assign chnl_last  = (chnl == chnl_max - NW'(1));
    assign first_chnl = (chnl == '0);

endmodule

// File: rtl/chnl_acum_ctrl.sv
// rtl/chnl_acum_ctrl.sv - channel-accumulation sequencer; optional stall counter under ACUM_STALL_CNT_EN
module chnl_acum_ctrl
    import acum_pkg::*;
#(
    parameter int WID  = WID_DEF,
    parameter int CHNL = CHNL_DEF,
    parameter int CW   = $clog2(WID),
    parameter int NW   = $clog2(CHNL) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] cfg_chnl,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          acc_en,
    output logic          acc_load,
    output logic [CW-1:0] acc_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          done,
    output logic [31:0]   stall_cnt
);

    acum_state_t   state, state_nxt;
    logic [NW-1:0] chnl_max, cfg_eff;
    logic          start_acc, beat, out_stall, out_hs;
    logic          col_last, chnl_last, first_chnl;

    always_comb begin
        cfg_eff = cfg_chnl;
        if (cfg_chnl == '0)
            cfg_eff = NW'(1);
        else if (cfg_chnl > NW'(CHNL))
            cfg_eff = NW'(CHNL);
    end

    assign start_acc = start && (state == IDLE);
    assign out_stall = out_valid && !out_ready;
    assign out_hs    = out_valid && out_ready;
    // Back-pressure from the output register stops intake so no finished column is overwritten.
    assign in_ready  = (state == RUN) && !out_stall;
    assign beat      = in_valid && in_ready;

    assign acc_en    = beat;
    assign acc_load  = beat && first_chnl;
    assign busy      = (state != IDLE);

    acum_idx_cnt #(.WID(WID), .CHNL(CHNL), .CW(CW), .NW(NW)) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .en         (beat),
        .chnl_max   (chnl_max),
        .col        (acc_col),
        .col_last   (col_last),
        .chnl_last  (chnl_last),
        .first_chnl (first_chnl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                          state_nxt = RUN;
            RUN:     if (beat && chnl_last && col_last)  state_nxt = DRAIN;
            DRAIN:   if (out_hs)                         state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chnl_max  <= NW'(1);
            out_valid <= 1'b0;
            out_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_hs;
            if (start_acc)
                chnl_max <= cfg_eff;
            // A new last-channel beat can only land when the slot is empty or draining this cycle.
            if (beat && chnl_last) begin
                out_valid <= 1'b1;
                out_col   <= acc_col;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ACUM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (start_acc)
            stall_q <= '0;
        else if (out_stall && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_chnl_acum_ctrl.sv
// tb/tb_chnl_acum_ctrl.sv - scoreboard bench for chnl_acum_ctrl
module tb_chnl_acum_ctrl;

    localparam int WID  = 56;
    localparam int CHNL = 64;
    localparam int CW   = 6;
    localparam int NW   = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] cfg_chnl = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, acc_en, acc_load, out_valid, busy, done;
    logic [CW-1:0] acc_col, out_col;
    logic [31:0]   stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW:0]   exp_acc[$];
    logic [CW-1:0] exp_out[$];
    bit            done_exp = 1'b0;

    chnl_acum_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_chnl  (cfg_chnl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_en    (acc_en),
        .acc_load  (acc_load),
        .acc_col   (acc_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a finished column.
    always @(negedge clk) begin
        logic [CW:0] ea;
        if (!rst_n) begin
            done_exp = 1'b0;
        end else begin
            if (done_exp) begin
                check("done_after_last_hs", done, 1);
                check("busy_with_done", busy, 0);
            end else if (done) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_spurious: got 1 expected 0 at %0t", $time);
            end
            done_exp = 1'b0;
            if (acc_en) begin
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL acc_unexpected: got col %0d expected none", acc_col);
                end else begin
                    ea = exp_acc.pop_front();
                    check("acc_col", acc_col, ea[CW-1:0]);
                    check("acc_load", acc_load, ea[CW]);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got col %0d expected none", out_col);
                end else begin
                    check("out_col", out_col, exp_out.pop_front());
                    if (exp_out.size() == 0)
                        done_exp = 1'b1;
                end
            end
        end
    end

    task automatic push_pass(input int eff);
        for (int ch = 0; ch < eff; ch++)
            for (int c = 0; c < WID; c++)
                exp_acc.push_back({(ch == 0), CW'(c)});
        for (int c = 0; c < WID; c++)
            exp_out.push_back(CW'(c));
    endtask

    task automatic run_pass(input int cfg, input int eff, input bit rnd, input int stall_after,
                            input int bogus_start_at, output int first_ov, output int last_ov);
        int beats, outs, cyc, stall_left, exp_stall;
        bit got_done, stalled;
        logic [CW-1:0] held;
        beats = 0; outs = 0; cyc = 0; stall_left = 0;
        got_done = 0; stalled = 0; held = '0;
        first_ov = -1; last_ov = -1;
        push_pass(eff);
        @(posedge clk); #1;
        cfg_chnl = NW'(cfg);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_chnl = '0;
        while (!got_done && cyc < 20000) begin
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = (stall_left == 0);
            start     = (cyc == bogus_start_at);
            cfg_chnl  = start ? NW'(5) : '0;
            @(negedge clk);
            if (stall_left > 0) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                if (stall_left == 5) held = out_col;
                else check("stall_out_col_held", out_col, held);
                stall_left--;
            end
            if (acc_en) beats++;
            if (out_valid && out_ready) outs++;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
            end
            if (stall_after > 0 && beats == stall_after && !stalled) begin
                stall_left = 5;
                stalled = 1;
            end
            if (done) got_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
`ifdef ACUM_STALL_CNT_EN
        exp_stall = stalled ? 5 : 0;
`else
        exp_stall = 0;
`endif
        check("pass_done_seen", got_done, 1);
        check("pass_beats", beats, eff * WID);
        check("pass_outputs", outs, WID);
        check("pass_busy_after", busy, 0);
        check("pass_acc_queue_empty", exp_acc.size(), 0);
        check("pass_stall_cnt", stall_cnt, exp_stall);
    endtask

    initial begin
        int f, l;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acc_col", acc_col, 0);
        check("rst_out_col", out_col, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: two channels, continuous flow, finished columns back to back
        run_pass(2, 2, 0, 0, -1, f, l);
        check("t1_out_valid_contiguous", l - f + 1, WID);

        // 2: zero channels behaves as one
        run_pass(0, 1, 0, 0, -1, f, l);

        // 3: five-cycle back-pressure in the last channel
        run_pass(2, 2, 0, WID + 10, -1, f, l);

        // 4: in_valid while idle is ignored, then a start pulse during RUN is ignored
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_acc_en", acc_en, 0);
            check("idle_in_ready", in_ready, 0);
            check("idle_acc_col", acc_col, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        run_pass(2, 2, 0, 0, 20, f, l);

        // 5: reset in the middle of channel 1, then a clean pass
        push_pass(2);
        cfg_chnl = NW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_acc_en", acc_en, 0);
        check("mid_rst_acc_load", acc_load, 0);
        check("mid_rst_acc_col", acc_col, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_col", out_col, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        exp_acc.delete();
        exp_out.delete();
        in_valid = 1'b0;
        cfg_chnl = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_pass(2, 2, 0, 0, -1, f, l);

        // 6: full 64 channels with a random in_valid pattern
        run_pass(64, 64, 1, 0, -1, f, l);

        // channel count above the maximum clamps to 64
        run_pass(100, CHNL, 0, 0, -1, f, l);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
